// File: rtl/gcd_frac_reduce.sv
// -----------------------------------------------------------------------------
// gcd_frac_reduce
//
// Reduces the fraction A/B by a supplied GCD G, producing A/G and B/G.
// A single restoring-division sequencer runs both divisions in lock-step,
// producing one quotient bit per cycle (W cycles per result).
//
// Handshake (both sides): a transfer happens on a rising edge where
// valid && ready are both high. A producer holds valid and data stable until
// the transfer occurs. in_ready is high only in IDLE. out_valid is high only
// in DONE, and out_a/out_b/out_err are held stable while out_valid && !out_ready.
//
// Configuration macro:
//   REDUCE_CHECK_EN - when defined, out_err also flags a G that leaves a
//                     non-zero remainder on either operand. When undefined,
//                     out_err is raised only for G == 0.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   reset      - synchronous, active-high reset
//   in_valid   - upstream presents a valid {in_a, in_b, in_g} triple
//   in_ready   - block can accept a triple (IDLE only)
//   in_a       - numerator operand
//   in_b       - denominator operand
//   in_g       - GCD of in_a and in_b
//   out_valid  - out_a, out_b, out_err are valid
//   out_ready  - downstream accepts the result
//   out_a      - floor(in_a / in_g)
//   out_b      - floor(in_b / in_g)
//   out_err    - result flagged invalid
//   dbg_state  - current FSM state (0 IDLE, 1 DIV, 2 DONE)
// -----------------------------------------------------------------------------
module gcd_frac_reduce #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic [W-1:0] in_g,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_a,
   output logic [W-1:0] out_b,
   output logic         out_err,
   output logic [1:0]   dbg_state
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_next;

   logic [CW-1:0]   r_cnt;
   logic [W-1:0]    r_g;
   logic [W-1:0]    r_q_a;
   logic [W-1:0]    r_q_b;
   logic [W-1:0]    r_rem_a;
   logic [W-1:0]    r_rem_b;
   logic [W-1:0]    r_out_a;
   logic [W-1:0]    r_out_b;
   logic            r_out_err;

   logic [W:0]      w_g_ext;
   logic [W:0]      w_sh_a;
   logic [W:0]      w_sh_b;
   logic            w_ge_a;
   logic            w_ge_b;
   logic [W-1:0]    w_diff_a;
   logic [W-1:0]    w_diff_b;
   logic [W-1:0]    w_rem_a_nxt;
   logic [W-1:0]    w_rem_b_nxt;
   logic [W-1:0]    w_q_a_nxt;
   logic [W-1:0]    w_q_b_nxt;

   // ---------------------------------------------------------------------------
   // One restoring-division step for each operand.
   // The shifted partial remainder is W+1 bits so the compare cannot overflow
   // even at A = G = 2^W-1. When the shifted value is >= G, the true difference
   // is < G <= 2^W-1, so a W-bit subtraction of the low bits is exact.
   // ---------------------------------------------------------------------------
   assign w_g_ext     = {1'b0, r_g};
   assign w_sh_a      = {r_rem_a, r_q_a[W-1]};
   assign w_sh_b      = {r_rem_b, r_q_b[W-1]};
   assign w_ge_a      = (w_sh_a >= w_g_ext);
   assign w_ge_b      = (w_sh_b >= w_g_ext);
   assign w_diff_a    = w_sh_a[W-1:0] - r_g;
   assign w_diff_b    = w_sh_b[W-1:0] - r_g;
   assign w_rem_a_nxt = w_ge_a ? w_diff_a : w_sh_a[W-1:0];
   assign w_rem_b_nxt = w_ge_b ? w_diff_b : w_sh_b[W-1:0];
   assign w_q_a_nxt   = {r_q_a[W-2:0], w_ge_a};
   assign w_q_b_nxt   = {r_q_b[W-2:0], w_ge_b};

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next-state and handshake outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_state_next = (in_g == '0) ? DONE : DIV;
            end
         end
         DIV: begin
            if (r_cnt == '0) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath: operand latch, division sequencer, result registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt     <= '0;
         r_g       <= '0;
         r_q_a     <= '0;
         r_q_b     <= '0;
         r_rem_a   <= '0;
         r_rem_b   <= '0;
         r_out_a   <= '0;
         r_out_b   <= '0;
         r_out_err <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_g     <= in_g;
                  r_q_a   <= in_a;
                  r_q_b   <= in_b;
                  r_rem_a <= '0;
                  r_rem_b <= '0;
                  r_cnt   <= CW'(W - 1);
                  // Division by zero is reported immediately, skipping DIV.
                  if (in_g == '0) begin
                     r_out_a   <= '0;
                     r_out_b   <= '0;
                     r_out_err <= 1'b1;
                  end
               end
            end
            DIV: begin
               r_q_a   <= w_q_a_nxt;
               r_q_b   <= w_q_b_nxt;
               r_rem_a <= w_rem_a_nxt;
               r_rem_b <= w_rem_b_nxt;
               if (r_cnt == '0) begin
                  r_out_a <= w_q_a_nxt;
                  r_out_b <= w_q_b_nxt;
`ifdef REDUCE_CHECK_EN
                  // A non-zero final remainder means G is not a common divisor.
                  r_out_err <= (w_rem_a_nxt != '0) || (w_rem_b_nxt != '0);
`else
                  r_out_err <= 1'b0;
`endif
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
               // DONE: results held until the handoff; nothing to update.
            end
         endcase
      end
   end

   assign out_a     = r_out_a;
   assign out_b     = r_out_b;
   assign out_err   = r_out_err;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_gcd_frac_reduce.sv
module tb_gcd_frac_reduce;

  localparam int W = 16;
`ifdef REDUCE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] in_g;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_a;
  logic [W-1:0] out_b;
  logic         out_err;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // expected {err, b, a}
  logic [2*W:0] exp_q[$];

  gcd_frac_reduce #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_g      (in_g),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_err   (out_err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Presents a triple for one accept edge, then counts edges until out_valid.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] g, output int lat);
    check_eq("in_ready_before_send", in_ready, 1);
    in_a = a; in_b = b; in_g = g; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] g, input logic [W-1:0] ea,
                        input logic [W-1:0] eb, input logic ee, input int elat);
    int lat;
    logic [2*W:0] e;
    exp_q.push_back({ee, eb, ea});
    out_ready = 1'b1;
    send(a, b, g, lat);
    e = exp_q.pop_front();
    check_eq({tag, "_latency"}, lat, elat);
    check_eq({tag, "_out_valid"}, out_valid, 1);
    check_eq({tag, "_out_a"}, out_a, e[W-1:0]);
    check_eq({tag, "_out_b"}, out_b, e[2*W-1:W]);
    check_eq({tag, "_out_err"}, out_err, e[2*W]);
    @(posedge clk); #1;
    check_eq({tag, "_valid_after_handoff"}, out_valid, 0);
    check_eq({tag, "_in_ready_after_handoff"}, in_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    logic [W-1:0] held_a, held_b;
    logic held_err;

    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_g = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check_eq("rst_state", dbg_state, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_a", out_a, 0);
    check_eq("rst_out_b", out_b, 0);
    check_eq("rst_out_err", out_err, 0);

    // Directed vectors with hand-computed quotients.
    run_op("12_18_6",     16'd12,   16'd18,   16'd6,    16'd2,    16'd3,     1'b0, W);
    run_op("ffff_ffff",   16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd1,    16'd1,     1'b0, W);
    run_op("ffff_1_1",    16'hFFFF, 16'd1,    16'd1,    16'hFFFF, 16'd1,     1'b0, W);
    run_op("g_zero",      16'd5,    16'd7,    16'd0,    16'd0,    16'd0,     1'b1, 0);
    run_op("0_9_9",       16'd0,    16'd9,    16'd9,    16'd0,    16'd1,     1'b0, W);
    run_op("10_15_4",     16'd10,   16'd15,   16'd4,    16'd2,    16'd3,     CHK,  W);
    // 65535/3 = 21845 r0 ; 32768/3 = 10922 r2
    run_op("ffff_8000_3", 16'hFFFF, 16'h8000, 16'd3,    16'd21845, 16'd10922, CHK, W);

    // Backpressure: out_ready low for 5 cycles after out_valid.
    out_ready = 1'b0;
    send(16'd12, 16'd18, 16'd6, lat);
    check_eq("bp_latency", lat, W);
    held_a = out_a; held_b = out_b; held_err = out_err;
    check_eq("bp_out_a", out_a, 2);
    check_eq("bp_out_b", out_b, 3);
    for (int i = 0; i < 5; i++) begin
      in_a = 16'd99; in_b = 16'd33; in_g = 16'd11; in_valid = 1'b1;
      @(posedge clk); #1;
      check_eq("bp_valid_held", out_valid, 1);
      check_eq("bp_in_ready_low", in_ready, 0);
      check_eq("bp_a_stable", out_a, held_a);
      check_eq("bp_b_stable", out_b, held_b);
      check_eq("bp_err_stable", out_err, held_err);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_handoff_valid", out_valid, 0);
    check_eq("bp_handoff_in_ready", in_ready, 1);
    check_eq("bp_handoff_state", dbg_state, 0);
    check_eq("bp_out_a_kept", out_a, 2);
    check_eq("bp_out_b_kept", out_b, 3);

    // Reset mid-division aborts the operation.
    in_a = 16'd12; in_b = 16'd18; in_g = 16'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("midrst_state", dbg_state, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_out_a", out_a, 0);
    check_eq("midrst_out_b", out_b, 0);
    check_eq("midrst_out_err", out_err, 0);
    run_op("after_rst_8_4_4", 16'd8, 16'd4, 16'd4, 16'd2, 16'd1, 1'b0, W);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
